dmem_access_ctrl: RTL

//  MEM-stage controller that sequences data-memory accesses for the instruction held in the EX/MEM register.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/lsu_lane.sv | 48 ++++
 rtl/dmem_access_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory access controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unlisted size codes behave as word accesses, so they need word alignment.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_B, F3_BU: return 1'b0;
      F3_H, F3_HU: return a[0];
      default:     return a != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: store byte enables / replicated write data, and load
// byte/half selection with sign or zero extension.
module lsu_lane
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  boff,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [31:0] rsh;

  assign rsh = rdata >> {boff, 3'b000};

  always_comb begin
    be         = 4'hF;
    wdata_lane = wdata;
    rdata_ext  = rdata;
    case (funct3)
      F3_B: begin
        be         = 4'b0001 << boff;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{rsh[7]}}, rsh[7:0]};
      end
      F3_BU: begin
        be         = 4'b0001 << boff;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {24'h0, rsh[7:0]};
      end
      F3_H: begin
        be         = 4'b0011 << boff;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{rsh[15]}}, rsh[15:0]};
      end
      F3_HU: begin
        be         = 4'b0011 << boff;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {16'h0, rsh[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: drives a req/gnt/rvalid port, stalls the
// pipeline while an access is outstanding, and flags misalignment and timeouts.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int TMO_CYC = 255,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          readm,
  input  logic          memWrtm,
  input  logic [2:0]    funct3m,
  input  logic [31:0]   aluRsltm,
  input  logic [31:0]   wrtDm,
  output logic          memReq,
  output logic          memWe,
  output logic [AW-1:0] memAddr,
  output logic [3:0]    memBe,
  output logic [31:0]   memWdata,
  input  logic          memGnt,
  input  logic          memRvalid,
  input  logic [31:0]   memRdata,
  output logic          stallMem,
  output logic [31:0]   rdDatam,
  output logic          rdValidm,
  output logic          misAlgn,
  output logic          busErr
);

  // state | meaning
  // IDLE  | nothing outstanding; issues a request when EX/MEM holds a load/store
  // REQ   | request presented, waiting for memGnt
  // RESP  | load granted, waiting for memRvalid
  // DONE  | access finished; pipeline released, result pulses emitted

  localparam int CW = (TMO_CYC > 1) ? $clog2(TMO_CYC + 1) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          post_rst_q;
  logic          done_ld_q, done_mis_q, done_err_q;
  logic          done_ld_d, done_mis_d, done_err_d;
  logic [31:0]   rd_q;
  logic          rd_cap;
  logic          acc, mis, tmo_hit;
  logic [31:0]   ld_ext;

  // The instruction still sitting in EX/MEM right after reset is not issued.
  assign acc     = (readm | memWrtm) & ~post_rst_q;
  assign mis     = is_misaligned(funct3m, aluRsltm[1:0]);
  assign tmo_hit = (TMO_CYC != 0) && ((int'(cnt_q) + 1) == TMO_CYC);

  assign memWe   = memWrtm;
  assign memAddr = {aluRsltm[AW-1:2], 2'b00};
  assign rdDatam = rd_q;

  lsu_lane u_lane (
    .funct3     (funct3m),
    .boff       (aluRsltm[1:0]),
    .wdata      (wrtDm),
    .rdata      (memRdata),
    .be         (memBe),
    .wdata_lane (memWdata),
    .rdata_ext  (ld_ext)
  );

  always_comb begin
    state_d    = state_q;
    memReq     = 1'b0;
    stallMem   = 1'b0;
    rdValidm   = 1'b0;
    misAlgn    = 1'b0;
    busErr     = 1'b0;
    done_ld_d  = 1'b0;
    done_mis_d = 1'b0;
    done_err_d = 1'b0;
    rd_cap     = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc) begin
          stallMem = 1'b1;
          if (mis) begin
            state_d    = DONE;
            done_mis_d = 1'b1;
          end else begin
            memReq = 1'b1;
            if (memGnt) state_d = memWrtm ? DONE : RESP;
            else        state_d = REQ;
          end
        end
      end
      REQ: begin
        stallMem = 1'b1;
        memReq   = 1'b1;
        if (memGnt) begin
          state_d = memWrtm ? DONE : RESP;
        end else if (tmo_hit) begin
          state_d    = DONE;
          done_err_d = 1'b1;
        end
      end
      RESP: begin
        stallMem = 1'b1;
        if (memRvalid) begin
          rd_cap    = 1'b1;
          state_d   = DONE;
          done_ld_d = 1'b1;
        end else if (tmo_hit) begin
          state_d    = DONE;
          done_err_d = 1'b1;
        end
      end
      DONE: begin
        rdValidm = done_ld_q;
        misAlgn  = done_mis_q;
        busErr   = done_err_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_q       <= '0;
      done_ld_q  <= 1'b0;
      done_mis_q <= 1'b0;
      done_err_q <= 1'b0;
      post_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      post_rst_q <= 1'b0;
      done_ld_q  <= done_ld_d;
      done_mis_q <= done_mis_d;
      done_err_q <= done_err_d;
      if ((state_q == REQ || state_q == RESP) && state_d == state_q) cnt_q <= cnt_q + CW'(1);
      else                                                           cnt_q <= '0;
      if (rd_cap) rd_q <= ld_ext;
    end
  end

endmodule
